// File: rtl/bcd_hour_counter_if.sv
// Bus bundle for the BCD hour counter: hour carry, load port and hour display outputs.
interface bcd_hour_counter_if;
  logic       c_hr;
  logic       set_en;
  logic [1:0] set_lhbcd;
  logic [3:0] set_rhbcd;
  logic       set_pm;
  logic [1:0] lhbcd;
  logic [3:0] rhbcd;
  logic       pm;
  logic       c_day;
  logic       set_err;

  modport master (
    output c_hr, set_en, set_lhbcd, set_rhbcd, set_pm,
    input  lhbcd, rhbcd, pm, c_day, set_err
  );

  modport slave (
    input  c_hr, set_en, set_lhbcd, set_rhbcd, set_pm,
    output lhbcd, rhbcd, pm, c_day, set_err
  );
endinterface

// File: rtl/bcd_hour_counter.sv
// Two-digit BCD hour counter (12h with AM/PM or 24h) advanced by rising edges of c_hr.
// Define BCD_HOUR_CHR_SYNC_EN to put c_hr through a two-flop synchroniser before edge detection.
module bcd_hour_counter #(
  parameter bit HOUR24 = 1'b0
) (
  input  logic               CLK,
  input  logic               clear,
  bcd_hour_counter_if.slave  bus
);

`ifdef BCD_HOUR_CHR_SYNC_EN
  localparam int SYNC_LEN = 2;
`else
  localparam int SYNC_LEN = 1;
`endif

  localparam logic [1:0] RST_L = HOUR24 ? 2'd0 : 2'd1;
  localparam logic [3:0] RST_R = HOUR24 ? 4'd0 : 4'd2;

  logic [SYNC_LEN-1:0] chr_pipe;
  logic                chr_cur;
  logic                chr_prev;
  logic                chr_evt;

  logic [1:0] hr_l_reg;
  logic [3:0] hr_r_reg;
  logic       pm_reg;
  logic       c_day_reg;
  logic       set_err_reg;

  logic [1:0] cnt_l;
  logic [3:0] cnt_r;
  logic       cnt_pm;
  logic       cnt_day;
  logic       ld_legal;
  logic       ld_pm;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_LEN; gi++) begin : g_sync
      logic d;
      logic q;
      if (gi == 0) begin : g_first
        assign d = bus.c_hr;
      end else begin : g_rest
        assign d = chr_pipe[gi-1];
      end
      always_ff @(posedge CLK or posedge clear) begin
        if (clear) q <= 1'b0;
        else       q <= d;
      end
      assign chr_pipe[gi] = q;
    end
  endgenerate

  assign chr_cur = chr_pipe[SYNC_LEN-1];
  assign chr_evt = chr_cur & ~chr_prev;

  // Next hour on a count event; an out-of-range held state falls back to the reset hour.
  always_comb begin
    cnt_l   = RST_L;
    cnt_r   = RST_R;
    cnt_pm  = 1'b0;
    cnt_day = 1'b0;
    if (HOUR24) begin
      if ((hr_l_reg < 2'd2 && hr_r_reg <= 4'd9) || (hr_l_reg == 2'd2 && hr_r_reg <= 4'd3)) begin
        if (hr_l_reg == 2'd2 && hr_r_reg == 4'd3) begin
          cnt_l   = 2'd0;
          cnt_r   = 4'd0;
          cnt_day = 1'b1;
        end else if (hr_r_reg == 4'd9) begin
          cnt_l = hr_l_reg + 2'd1;
          cnt_r = 4'd0;
        end else begin
          cnt_l = hr_l_reg;
          cnt_r = hr_r_reg + 4'd1;
        end
        cnt_pm = (cnt_l == 2'd2) || (cnt_l == 2'd1 && cnt_r >= 4'd2);
      end
    end else begin
      if ((hr_l_reg == 2'd0 && hr_r_reg >= 4'd1 && hr_r_reg <= 4'd9) ||
          (hr_l_reg == 2'd1 && hr_r_reg <= 4'd2)) begin
        cnt_pm = pm_reg;
        if (hr_l_reg == 2'd1 && hr_r_reg == 4'd2) begin
          cnt_l = 2'd0;
          cnt_r = 4'd1;
        end else if (hr_l_reg == 2'd1 && hr_r_reg == 4'd1) begin
          cnt_l   = 2'd1;
          cnt_r   = 4'd2;
          cnt_pm  = ~pm_reg;
          cnt_day = pm_reg;
        end else if (hr_r_reg == 4'd9) begin
          cnt_l = 2'd1;
          cnt_r = 4'd0;
        end else begin
          cnt_l = hr_l_reg;
          cnt_r = hr_r_reg + 4'd1;
        end
      end
    end
  end

  always_comb begin
    ld_legal = 1'b0;
    ld_pm    = bus.set_pm;
    if (HOUR24) begin
      ld_legal = (bus.set_lhbcd < 2'd2 && bus.set_rhbcd <= 4'd9) ||
                 (bus.set_lhbcd == 2'd2 && bus.set_rhbcd <= 4'd3);
      ld_pm    = (bus.set_lhbcd == 2'd2) || (bus.set_lhbcd == 2'd1 && bus.set_rhbcd >= 4'd2);
    end else begin
      ld_legal = (bus.set_lhbcd == 2'd0 && bus.set_rhbcd >= 4'd1 && bus.set_rhbcd <= 4'd9) ||
                 (bus.set_lhbcd == 2'd1 && bus.set_rhbcd <= 4'd2);
    end
  end

  // A load, accepted or not, swallows any count event detected in the same cycle.
  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      hr_l_reg    <= RST_L;
      hr_r_reg    <= RST_R;
      pm_reg      <= 1'b0;
      c_day_reg   <= 1'b0;
      set_err_reg <= 1'b0;
      chr_prev    <= 1'b0;
    end else begin
      chr_prev    <= chr_cur;
      c_day_reg   <= 1'b0;
      set_err_reg <= 1'b0;
      if (bus.set_en) begin
        if (ld_legal) begin
          hr_l_reg <= bus.set_lhbcd;
          hr_r_reg <= bus.set_rhbcd;
          pm_reg   <= ld_pm;
        end else begin
          set_err_reg <= 1'b1;
        end
      end else if (chr_evt) begin
        hr_l_reg  <= cnt_l;
        hr_r_reg  <= cnt_r;
        pm_reg    <= cnt_pm;
        c_day_reg <= cnt_day;
      end
    end
  end

  assign bus.lhbcd   = hr_l_reg;
  assign bus.rhbcd   = hr_r_reg;
  assign bus.pm      = pm_reg;
  assign bus.c_day   = c_day_reg;
  assign bus.set_err = set_err_reg;

endmodule

// File: tb/tb_bcd_hour_counter.sv
// Scoreboard bench for bcd_hour_counter: one 12-hour and one 24-hour instance against a time-of-day model.
module tb_bcd_hour_counter;

`ifdef BCD_HOUR_CHR_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int         due;
    logic [1:0] l;
    logic [3:0] r;
    logic       p;
    logic       day;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic clear;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;

  logic [1:0] chr, sen, spm;
  logic [1:0] slh [2];
  logic [3:0] srh [2];
  logic [1:0] al  [2];
  logic [3:0] ar  [2];
  logic [1:0] ap, ad, ae;

  // Model state: hour of day 0..23 per instance (0 = midnight).
  int   hr [2];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t cur [2];

  bcd_hour_counter_if bus0 ();
  bcd_hour_counter_if bus1 ();

  bcd_hour_counter #(.HOUR24(1'b0)) dut12 (.CLK(clk), .clear(clear), .bus(bus0));
  bcd_hour_counter #(.HOUR24(1'b1)) dut24 (.CLK(clk), .clear(clear), .bus(bus1));

  assign bus0.c_hr = chr[0];     assign bus1.c_hr = chr[1];
  assign bus0.set_en = sen[0];   assign bus1.set_en = sen[1];
  assign bus0.set_pm = spm[0];   assign bus1.set_pm = spm[1];
  assign bus0.set_lhbcd = slh[0]; assign bus1.set_lhbcd = slh[1];
  assign bus0.set_rhbcd = srh[0]; assign bus1.set_rhbcd = srh[1];
  assign al[0] = bus0.lhbcd;  assign al[1] = bus1.lhbcd;
  assign ar[0] = bus0.rhbcd;  assign ar[1] = bus1.rhbcd;
  assign ap = {bus1.pm, bus0.pm};
  assign ad = {bus1.c_day, bus0.c_day};
  assign ae = {bus1.set_err, bus0.set_err};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t disp(input int m, input int h, input int due, input bit day, input bit err);
    exp_t e;
    int   v;
    v     = (m == 0) ? ((h % 12 == 0) ? 12 : h % 12) : h;
    e.due = due;
    e.l   = 2'(v / 10);
    e.r   = 4'(v % 10);
    e.p   = (h >= 12);
    e.day = day;
    e.err = err;
    return e;
  endfunction

  task automatic push(input int m, input exp_t e);
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic cmp(input int m, input string name, input exp_t e);
    checks++;
    if (al[m] !== e.l || ar[m] !== e.r || ap[m] !== e.p || ad[m] !== e.day || ae[m] !== e.err) begin
      failures++;
      $display("FAIL %s unit=%0d cyc=%0d actual=%0d%0d pm=%b c_day=%b set_err=%b required=%0d%0d pm=%b c_day=%b set_err=%b",
               name, m, cyc, al[m], ar[m], ap[m], ad[m], ae[m], e.l, e.r, e.p, e.day, e.err);
    end
  endtask

  task automatic mon(input int m);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (m == 0 && q0.size() > 0) begin e = q0[0]; have = 1'b1; end
    if (m == 1 && q1.size() > 0) begin e = q1[0]; have = 1'b1; end
    if (have && e.due == cyc) begin
      if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      cmp(m, "txn", e);
      $display("txn unit=%0d cyc=%0d hour=%0d%0d pm=%b c_day=%b set_err=%b", m, cyc, al[m], ar[m], ap[m], ad[m], ae[m]);
      cur[m]     = e;
      cur[m].day = 1'b0;
      cur[m].err = 1'b0;
    end else if (have && e.due < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed unit=%0d cyc=%0d actual=none required_at=%0d", m, cyc, e.due);
      if (m == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end else begin
      cmp(m, "idle", cur[m]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int m = 0; m < 2; m++) mon(m);
    end
  end

  task automatic count_pulse(input int m, input int hold);
    bit day;
    @(posedge clk); #2;
    chr[m] = 1'b1;
    day    = (hr[m] == 23);
    hr[m]  = (hr[m] + 1) % 24;
    push(m, disp(m, hr[m], cyc + LAT, day, 1'b0));
    repeat (hold) @(posedge clk);
    #2 chr[m] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Applies a load to the model and returns the expected response for the sampling edge.
  function automatic exp_t apply_load(input int m, input int t, input int u, input bit p, input int due);
    int v;
    bit ok;
    v  = t * 10 + u;
    ok = (u <= 9) && ((m == 0) ? (v >= 1 && v <= 12) : (v <= 23));
    if (ok) hr[m] = (m == 0) ? ((v % 12) + (p ? 12 : 0)) : v;
    return disp(m, hr[m], due, 1'b0, !ok);
  endfunction

  task automatic load(input int m, input int t, input int u, input bit p);
    @(posedge clk); #2;
    sen[m] = 1'b1;
    slh[m] = 2'(t);
    srh[m] = 4'(u);
    spm[m] = p;
    push(m, apply_load(m, t, u, p, cyc + 1));
    @(posedge clk); #2;
    sen[m] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Load arrives on exactly the edge that would apply the pending count.
  task automatic collide(input int m, input int t, input int u, input bit p);
    @(posedge clk); #2;
    chr[m] = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #2;
    sen[m] = 1'b1;
    slh[m] = 2'(t);
    srh[m] = 4'(u);
    spm[m] = p;
    push(m, apply_load(m, t, u, p, cyc + 1));
    @(posedge clk); #2;
    sen[m] = 1'b0;
    @(posedge clk); #2;
    chr[m] = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic reset_model();
    q0.delete();
    q1.delete();
    for (int m = 0; m < 2; m++) begin
      hr[m]  = 0;
      cur[m] = disp(m, 0, 0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int m, op, t, u;
    clear = 1'b0;
    chr = '0; sen = '0; spm = '0;
    for (int i = 0; i < 2; i++) begin slh[i] = '0; srh[i] = '0; end
    reset_model();
    #1 clear = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 clear = 1'b0;
    repeat (2) @(posedge clk);

    // Clear in the middle of a count: the pending advance is lost.
    @(posedge clk); #2 chr[0] = 1'b1;
    @(posedge clk); #3;
    clear = 1'b1;
    reset_model();
    chr[0] = 1'b0;
    @(posedge clk); #2 clear = 1'b0;
    repeat (3) @(posedge clk);

    // Full day in 12-hour mode: 24 pulses from 12 AM back to 12 AM.
    for (int i = 0; i < 24; i++) count_pulse(0, 2 + (i % 3));

    // 24-hour mode: 23 -> 00 with day carry, then up to 12.
    load(1, 2, 3, 1'b0);
    count_pulse(1, 2);
    for (int i = 0; i < 12; i++) count_pulse(1, 2);

    // Range checks on the load port.
    load(0, 1, 3, 1'b0);
    load(0, 0, 0, 1'b0);
    load(1, 1, 10, 1'b0);
    load(0, 0, 7, 1'b1);

    // Collisions and a long held carry.
    collide(0, 0, 5, 1'b0);
    count_pulse(0, 20);
    collide(1, 3, 0, 1'b0);
    collide(1, 1, 5, 1'b1);

    for (int i = 0; i < 60; i++) begin
      m  = $urandom_range(0, 1);
      op = $urandom_range(0, 9);
      t  = $urandom_range(0, 3);
      u  = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      if (op <= 5)      count_pulse(m, $urandom_range(2, 6));
      else if (op <= 8) load(m, t, u, 1'($urandom_range(0, 1)));
      else              collide(m, t, u, 1'($urandom_range(0, 1)));
    end

    repeat (10) @(posedge clk);
    checks++;
    if (q0.size() + q1.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", q0.size() + q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
